mux_8x1: RTL and testbench



---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_2x1.sv | 13 +
 rtl/mux_4x1.sv | 24 ++
 rtl/mux_8x1.sv | 61 ++++++
 tb/tb_mux_8x1.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants and types for the hierarchical 8-to-1 selector.
// Lane count and select widths live here so the sub-selectors agree on them.
package mux_pkg;

    localparam int N_IN       = 8;
    localparam int SEL_W      = 3;
    localparam int QUAD_SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_2x1.sv
// Combinational 2-to-1 selector: y = sel ? b : a.
module mux_2x1 #(
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux_4x1.sv
// Combinational 4-to-1 lane selector; out = lane sel of the packed input.
// An unknown select drives X on the output rather than picking a lane.
module mux_4x1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [4*WIDTH-1:0]    i,
    input  logic [QUAD_SEL_W-1:0] sel,
    output logic [WIDTH-1:0]      out
);

    always_comb begin
        out = '0;
        case (sel)
            2'd0:    out = i[0*WIDTH +: WIDTH];
            2'd1:    out = i[1*WIDTH +: WIDTH];
            2'd2:    out = i[2*WIDTH +: WIDTH];
            2'd3:    out = i[3*WIDTH +: WIDTH];
            default: out = 'x;
        endcase
    end

endmodule

// File: rtl/mux_8x1.sv
// Registered 8-to-1 selector built from two 4-to-1 quartets and a 2-to-1 stage.
// y_comb is the same-cycle selection; y/out_valid are the one-cycle registered copy.
module mux_8x1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] i,
    input  sel_t                  sel,
    input  logic                  in_valid,
    output logic [WIDTH-1:0]      y,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      y_comb
);

    logic [WIDTH-1:0] out_lo;
    logic [WIDTH-1:0] out_hi;
    logic [WIDTH-1:0] y_q, y_d;
    logic             out_valid_q, out_valid_d;

    mux_4x1 #(.WIDTH(WIDTH)) u_quad_lo (
        .i   (i[4*WIDTH-1:0]),
        .sel (sel[QUAD_SEL_W-1:0]),
        .out (out_lo)
    );

    mux_4x1 #(.WIDTH(WIDTH)) u_quad_hi (
        .i   (i[8*WIDTH-1:4*WIDTH]),
        .sel (sel[QUAD_SEL_W-1:0]),
        .out (out_hi)
    );

    mux_2x1 #(.WIDTH(WIDTH)) u_final (
        .y   (y_comb),
        .a   (out_lo),
        .b   (out_hi),
        .sel (sel[SEL_W-1])
    );

    // y holds across idle cycles; out_valid is a pure one-cycle echo of in_valid.
    always_comb begin
        y_d         = in_valid ? y_comb : y_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_8x1.sv
// Randomized and directed bench for mux_8x1 at WIDTH=1 and WIDTH=8,
// compared against a shift-and-mask reference model.
module tb_mux_8x1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i1 = '0;
    logic [63:0] i8 = '0;
    logic [2:0]  sel = '0;
    logic        in_valid = 1'b0;

    logic        y1, yc1, ov1;
    logic [7:0]  y8, yc8;
    logic        ov8;

    logic        m_y1 = 1'b0;
    logic [7:0]  m_y8 = '0;
    logic        m_v  = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mux_8x1 #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (i1),
        .sel       (sel),
        .in_valid  (in_valid),
        .y         (y1),
        .out_valid (ov1),
        .y_comb    (yc1)
    );

    mux_8x1 #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i         (i8),
        .sel       (sel),
        .in_valid  (in_valid),
        .y         (y8),
        .out_valid (ov8),
        .y_comb    (yc8)
    );

    function automatic logic ref1(input logic [7:0] a, input logic [2:0] s);
        logic [7:0] t;
        t = a >> s;
        return t[0];
    endfunction

    function automatic logic [7:0] ref8(input logic [63:0] b, input logic [2:0] s);
        logic [63:0] t;
        t = (b >> (32'(s) * 8)) & 64'hFF;
        return t[7:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_regs();
        check("y1", 64'(y1), 64'(m_y1));
        check("ov1", 64'(ov1), 64'(m_v));
        check("y8", 64'(y8), 64'(m_y8));
        check("ov8", 64'(ov8), 64'(m_v));
    endtask

    // Drive one request at the falling edge, check the comb path, then the registered path.
    task automatic step(input logic v, input logic [2:0] s, input logic [7:0] a, input logic [63:0] b);
        @(negedge clk);
        in_valid = v;
        sel      = s;
        i1       = a;
        i8       = b;
        #1;
        check("ycomb1", 64'(yc1), 64'(ref1(a, s)));
        check("ycomb8", 64'(yc8), 64'(ref8(b, s)));
        @(posedge clk);
        if (!rst_n) begin
            m_y1 = 1'b0;
            m_y8 = '0;
            m_v  = 1'b0;
        end else begin
            m_v = v;
            if (v) begin
                m_y1 = ref1(a, s);
                m_y8 = ref8(b, s);
            end
        end
        #1;
        check_regs();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [63:0] lanes;

        // Held in reset with live requests: outputs stay cleared.
        for (int k = 0; k < 4; k++)
            step(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), rnd64());

        // Release mid-cycle; outputs must not move until a clock edge.
        #3 rst_n = 1'b1;
        #1 check_regs();

        // Full select sweep at WIDTH=1 (and random wide lanes alongside).
        for (int s = 0; s < 8; s++)
            step(1'b1, 3'(s), 8'b1000_1110, rnd64());
        check("sweep_last", 64'(y1), 64'd1);

        // Hold: drop valid and zero the inputs.
        step(1'b0, 3'd7, 8'h00, 64'h0);
        check("hold_y", 64'(y1), 64'd1);
        check("hold_ov", 64'(ov1), 64'd0);

        // Wide lanes: lane k = 8'h10 + k.
        lanes = '0;
        for (int k = 0; k < 8; k++) lanes[k*8 +: 8] = 8'(8'h10 + k);
        step(1'b1, 3'd5, 8'h00, lanes);
        check("wide5", 64'(y8), 64'h15);
        step(1'b1, 3'd2, 8'h00, lanes);
        check("wide2", 64'(y8), 64'h12);

        // Quartet boundary.
        step(1'b1, 3'd3, 8'b0001_0000, lanes);
        check("quad3", 64'(y1), 64'd0);
        step(1'b1, 3'd4, 8'b0001_0000, lanes);
        check("quad4", 64'(y1), 64'd1);

        // Mid-stream reset while y=1, out_valid=1.
        #2 rst_n = 1'b0;
        m_y1 = 1'b0;
        m_y8 = '0;
        m_v  = 1'b0;
        #1 check_regs();
        step(1'b1, 3'd7, 8'hFF, lanes);
        #2 rst_n = 1'b1;
        step(1'b1, 3'd4, 8'b0001_0000, lanes);
        check("post_rst_y", 64'(y1), 64'd1);
        check("post_rst_ov", 64'(ov1), 64'd1);

        // Random traffic with random valid gaps.
        for (int k = 0; k < 200; k++)
            step(1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom), rnd64());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
